fifo_wr_arb: RTL and testbench
==============================

// Module: fifo_wr_arb
// PURPOSE
//   Round-robin write arbiter that shares one fifo_sv write port between NUM_REQ producers.
//   - Each producer has a valid/ready handshake.
//   - The arbiter grants one producer at a time for a burst of up to MAX_BURST beats.
//   - It drives fifo we/wdata and honours fifo full. It sits directly in front of fifo_sv.
// PARAMETERS
//   NUM_REQ    4  number of producers (2..8)
//   DATA_W     8  data width; matches fifo_sv wdata
//   MAX_BURST  4  maximum beats per grant before the grant is forced to rotate (>=1)
// PORTS
//   clk          in   1                 clock, rising edge
//   rst_n        in   1                 reset; asynchronous, active-low
//   req_valid    in   NUM_REQ           producer i has a byte to write
//   req_data     in   NUM_REQ*DATA_W    producer i data in slice [i*DATA_W +: DATA_W]
//   req_ready    out  NUM_REQ           beat of producer i is accepted this cycle
//   fifo_full    in   1                 full flag from fifo_sv
//   fifo_we      out  1                 fifo_sv we
//   fifo_wdata   out  DATA_W            fifo_sv wdata
//   grant_id     out  $clog2(NUM_REQ)   index of the current grant holder
//   busy         out  1                 state == HOLD
// BEHAVIOUR
//   Reset (async, while rst_n=0):
//     state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0.
//     req_ready=0, fifo_we=0, busy=0, fifo_wdata=0.
//   State registers: state, grant_id, rr_ptr, beat_cnt [$clog2(MAX_BURST+1)-1:0].
//   IDLE:
//     - req_ready=0, fifo_we=0.
//     - If any req_valid: pick the first valid index scanning up from rr_ptr, wrapping modulo NUM_REQ.
//     - Load grant_id with that index, clear beat_cnt, go to HOLD.
//     - Arbitration latency is 1 cycle from valid to the first possible beat.
//   HOLD, with g=grant_id:
//     - req_ready[g] = !fifo_full. All other req_ready bits are 0.
//     - fifo_we = req_valid[g] & !fifo_full.
//     - fifo_wdata = req_data slice g (combinational mux). fifo_wdata=0 when not HOLD.
//     - beat_cnt increments on each beat (fifo_we=1).
//   Exit HOLD to IDLE, setting rr_ptr = (g+1) mod NUM_REQ, on either condition:
//     - A beat occurs with beat_cnt == MAX_BURST-1 (burst limit reached).
//     - req_valid[g]==0 (producer done). No beat occurs that cycle.
//   Full handling:
//     - While fifo_full=1 in HOLD: no beat, beat_cnt holds, grant holds.
//     - A full stall is never a rotation trigger.
//   Bubble: exactly one IDLE cycle between consecutive grants.
//   Handshake rules:
//     - Producers hold data stable while valid && !ready.
//     - A beat is accepted iff req_valid & req_ready on a rising edge.
//     - Per-producer byte order is preserved end to end.
//   Fairness: with all producers valid continuously, grants cycle 0,1,..,NUM_REQ-1,0; each grant gets MAX_BURST beats.
//   Reset mid-burst: outputs drop to reset values asynchronously. After release, arbitration restarts from index 0.
//     A partially sent burst is not resumed.
// STRUCTURE
//   Package fifo_arb_pkg:
//     - typedef enum logic {IDLE, HOLD} arb_state_t.
//     - Localparams for default NUM_REQ/DATA_W/MAX_BURST.
//     - Function rr_next(ptr) for modulo increment.
//   Sub-module rr_pick (combinational, parameter N):
//     - Inputs: req[N], ptr.
//     - Outputs: any, idx. idx is the first set bit at or after ptr, with wrap.
//   fifo_wr_arb holds the FSM, counters and data mux.
// TESTING
//   Test bench instantiates fifo_wr_arb + fifo_sv (depth 16, 8-bit) and a per-producer scoreboard.
//   1. req0 sends 0x61,0x62,0x63, others idle.
//      -> grant_id=0 one cycle after valid; fifo_we high 3 cycles; the 4th cycle returns to IDLE; pops read 61,62,63.
//   2. All 4 producers valid continuously, MAX_BURST=4.
//      -> grant order 0,1,2,3,0; 4 beats per grant; one IDLE bubble between grants.
//   3. Pre-fill FIFO to 16 (full=1); req2 valid with 0xAA.
//      -> req_ready=0, fifo_we=0, beat_cnt frozen.
//      After one pop -> exactly one beat is accepted and 0xAA lands at the tail.
//   4. req1 drops valid after 2 beats while req3 is valid.
//      -> IDLE next cycle, rr_ptr=2, grant_id=3, req3 served.
//   5. rst_n low mid-burst (beat 2 of req0).
//      -> fifo_we/req_ready=0 in the same cycle; after release, a fresh grant is given to the lowest valid index from 0.
//   6. 256 random cycles of valid/data per producer with random pops.
//      -> zero scoreboard mismatches, no beat while full, and no producer starved longer than (NUM_REQ-1)*(MAX_BURST+1) grant cycles.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type, default sizes and round-robin pointer helper
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  // Modulo-n increment of a round-robin pointer.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, with wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter sharing one fifo_sv write port among NUM_REQ producers
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int GW        = $clog2(NUM_REQ),
  parameter int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_we,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
);

  arb_state_t    state, state_d;
  logic [GW-1:0] grant_d;
  logic [GW-1:0] rr_ptr, rr_ptr_d;
  logic [BW-1:0] beat_cnt, beat_cnt_d;

  logic          pick_any;
  logic [GW-1:0] pick_idx;
  logic          g_valid;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign g_valid = req_valid[grant_id];

  // Outputs are decoded from state only, so they collapse with the async reset.
  always_comb begin
    req_ready  = '0;
    fifo_we    = 1'b0;
    fifo_wdata = '0;
    busy       = 1'b0;
    if (state == HOLD) begin
      busy                = 1'b1;
      req_ready[grant_id] = !fifo_full;
      fifo_we             = g_valid & !fifo_full;
      fifo_wdata          = req_data[int'(grant_id)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state;
    grant_d    = grant_id;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d    = HOLD;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      HOLD: begin
        // A full stall leaves everything untouched; only a drop or the burst limit rotates.
        if (!g_valid) begin
          state_d  = IDLE;
          rr_ptr_d = GW'(rr_next(int'(grant_id), NUM_REQ));
        end else if (fifo_we) begin
          beat_cnt_d = beat_cnt + BW'(1);
          if (beat_cnt == BW'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = GW'(rr_next(int'(grant_id), NUM_REQ));
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      grant_id <= grant_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb with a behavioural 16-deep FIFO and per-producer scoreboard
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;
  localparam int GW    = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_we;
  logic [W-1:0]   fifo_wdata;
  logic [GW-1:0]  grant_id;
  logic           busy;

  fifo_wr_arb #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] d0;
    logic [N-1:0] r;
    logic         we;
    logic [W-1:0] wd;
    logic         bz;
    int           g;
  } vec_t;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] sb[N][$];
  bit           sb_on = 1'b0;
  int           we_count = 0;
  vec_t         tv[6];

  // Reference: who holds the grant (-1 = nobody), beats taken, next scan start.
  int           m_holder, m_beats, m_ptr, m_last;
  logic [N-1:0] e_ready;
  logic         e_we;
  logic [W-1:0] e_wdata;
  int           e_grant;
  logic         e_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_holder = -1;
    m_beats  = 0;
    m_ptr    = 0;
    m_last   = 0;
  endfunction

  function automatic void model_expect(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic full);
    e_ready = '0;
    e_we    = 1'b0;
    e_wdata = '0;
    e_busy  = 1'b0;
    e_grant = m_last;
    if (m_holder >= 0) begin
      e_busy  = 1'b1;
      e_grant = m_holder;
      if (!full) e_ready[m_holder] = 1'b1;
      e_we    = v[m_holder] & !full;
      e_wdata = d[m_holder*W +: W];
    end
  endfunction

  function automatic void model_step(input logic [N-1:0] v, input logic full);
    if (m_holder < 0) begin
      if (v != '0) begin
        for (int k = 0; k < N; k++) begin
          if (v[(m_ptr + k) % N]) begin
            m_holder = (m_ptr + k) % N;
            break;
          end
        end
        m_beats = 0;
        m_last  = m_holder;
      end
    end else if (!v[m_holder]) begin
      m_ptr    = (m_holder + 1) % N;
      m_holder = -1;
    end else if (!full) begin
      m_beats++;
      if (m_beats == MB) begin
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
      end
    end
  endfunction

  task automatic drive_sample(input logic [N-1:0] v, input logic [N*W-1:0] d);
    req_valid = v;
    req_data  = d;
    fifo_full = (fq.size() >= DEPTH);
    #1;
    model_expect(v, d, fifo_full);
    chk("ready", {60'd0, req_ready}, {60'd0, e_ready});
    chk("we", {63'd0, fifo_we}, {63'd0, e_we});
    chk("wdata", {56'd0, fifo_wdata}, {56'd0, e_wdata});
    chk("grant", {62'd0, grant_id}, 64'(e_grant));
    chk("busy", {63'd0, busy}, {63'd0, e_busy});
  endtask

  task automatic finish_cycle(input bit pop);
    logic [W-1:0] b;
    logic [W-1:0] exp_b;
    if (sb_on) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) sb[i].push_back(req_data[i*W +: W]);
    end
    if (fifo_we) we_count++;
    model_step(req_valid, fifo_full);
    if (pop && fq.size() > 0) begin
      b = fq.pop_front();
      if (sb_on) begin
        exp_b = 'x;
        if (sb[b[W-1 -: 2]].size() > 0) exp_b = sb[b[W-1 -: 2]].pop_front();
        chk("sb_order", {56'd0, b}, {56'd0, exp_b});
      end
    end
    if (fifo_we && !fifo_full && fq.size() < DEPTH) fq.push_back(fifo_wdata);
    @(negedge clk);
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit pop);
    drive_sample(v, d);
    finish_cycle(pop);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    #1;
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_we", {63'd0, fifo_we}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wdata", {56'd0, fifo_wdata}, 64'd0);
    chk("rst_grant", {62'd0, grant_id}, 64'd0);
    fq.delete();
    for (int i = 0; i < N; i++) sb[i].delete();
    model_reset();
    we_count = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] dd;
    logic [N-1:0]   pv;
    logic [W-1:0]   pd[N];
    int             pseq[N];
    int             wait_g[N];
    int             max_wait;
    int             grants[$];
    int             beats_per[$];
    int             bubbles[$];
    int             idle_run;
    int             gk;
    bit             prev_busy;
    int             sb_left;

    tv[0] = '{4'h1, 8'h61, 4'h0, 1'b0, 8'h00, 1'b0, 0};
    tv[1] = '{4'h1, 8'h61, 4'h1, 1'b1, 8'h61, 1'b1, 0};
    tv[2] = '{4'h1, 8'h62, 4'h1, 1'b1, 8'h62, 1'b1, 0};
    tv[3] = '{4'h1, 8'h63, 4'h1, 1'b1, 8'h63, 1'b1, 0};
    tv[4] = '{4'h0, 8'h00, 4'h1, 1'b0, 8'h00, 1'b1, 0};
    tv[5] = '{4'h0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_reset();
    @(negedge clk);

    // Single producer, three bytes.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      dd = '0;
      dd[W-1:0] = tv[k].d0;
      drive_sample(tv[k].v, dd);
      chk("t1_ready", {60'd0, req_ready}, {60'd0, tv[k].r});
      chk("t1_we", {63'd0, fifo_we}, {63'd0, tv[k].we});
      chk("t1_wdata", {56'd0, fifo_wdata}, {56'd0, tv[k].wd});
      chk("t1_busy", {63'd0, busy}, {63'd0, tv[k].bz});
      chk("t1_grant", {62'd0, grant_id}, 64'(tv[k].g));
      finish_cycle(1'b0);
    end
    chk("t1_count", 64'(fq.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_pop", {56'd0, (k < fq.size()) ? fq[k] : 8'hxx}, 64'(8'h61 + k));
    end

    // All producers continuously valid: fairness and bubbles.
    do_reset();
    prev_busy = 1'b0;
    idle_run  = 0;
    for (int c = 0; c < 26; c++) begin
      dd = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      drive_sample(4'hF, dd);
      if (busy && !prev_busy) begin
        if (grants.size() > 0) bubbles.push_back(idle_run);
        grants.push_back(int'(grant_id));
        beats_per.push_back(0);
        idle_run = 0;
      end
      if (!busy) idle_run++;
      if (fifo_we && beats_per.size() > 0) beats_per[beats_per.size()-1]++;
      prev_busy = busy;
      finish_cycle(1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      gk = (k < grants.size()) ? grants[k] : -1;
      chk("t2_grant_order", 64'(gk), 64'(k % N));
    end
    for (int k = 0; k < 4; k++) begin
      chk("t2_beats", 64'((k < beats_per.size()) ? beats_per[k] : -1), 64'(MB));
      chk("t2_bubble", 64'((k < bubbles.size()) ? bubbles[k] : -1), 64'd1);
    end

    // FIFO full stall, then a single pop releases exactly one beat.
    do_reset();
    for (int k = 0; k < DEPTH; k++) fq.push_back(8'(8'h10 + k));
    dd = '0;
    dd[2*W +: W] = 8'hAA;
    cycle(4'b0100, dd, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_sample(4'b0100, dd);
      chk("t3_beat_cnt_frozen", {61'd0, dut.beat_cnt}, 64'd0);
      finish_cycle(1'b0);
    end
    cycle(4'b0100, dd, 1'b1);
    cycle(4'b0100, dd, 1'b0);
    cycle(4'b0000, '0, 1'b0);
    chk("t3_beats", 64'(we_count), 64'd1);
    chk("t3_size", 64'(fq.size()), 64'(DEPTH));
    chk("t3_tail", {56'd0, (fq.size() > 0) ? fq[$] : 8'hxx}, 64'hAA);

    // Producer drop mid-burst hands over to the next valid index.
    do_reset();
    dd = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    cycle(4'b0010, dd, 1'b0);
    cycle(4'b1010, dd, 1'b0);
    cycle(4'b1010, dd, 1'b0);
    cycle(4'b1000, dd, 1'b0);
    drive_sample(4'b1000, dd);
    chk("t4_idle", {63'd0, busy}, 64'd0);
    chk("t4_rr_ptr", {62'd0, dut.rr_ptr}, 64'd2);
    finish_cycle(1'b0);
    drive_sample(4'b1000, dd);
    chk("t4_grant3", {62'd0, grant_id}, 64'd3);
    chk("t4_wdata3", {56'd0, fifo_wdata}, 64'hD3);
    finish_cycle(1'b0);
    cycle(4'b0000, dd, 1'b0);
    chk("t4_beats", 64'(we_count), 64'd3);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    dd = {8'hD3, 8'hC2, 8'hB1, 8'h51};
    cycle(4'b0001, dd, 1'b0);
    cycle(4'b0001, dd, 1'b0);
    drive_sample(4'b0001, dd);
    rst_n = 1'b0;
    #1;
    chk("t5_we_drop", {63'd0, fifo_we}, 64'd0);
    chk("t5_ready_drop", {60'd0, req_ready}, 64'd0);
    chk("t5_busy_drop", {63'd0, busy}, 64'd0);
    chk("t5_wdata_drop", {56'd0, fifo_wdata}, 64'd0);
    model_reset();
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0110, dd, 1'b0);
    drive_sample(4'b0110, dd);
    chk("t5_regrant", {62'd0, grant_id}, 64'd1);
    finish_cycle(1'b0);
    cycle(4'b0000, dd, 1'b0);

    // Random traffic with random pops against the scoreboard.
    do_reset();
    sb_on     = 1'b1;
    prev_busy = 1'b0;
    max_wait  = 0;
    for (int i = 0; i < N; i++) begin
      pv[i]     = 1'b0;
      pd[i]     = '0;
      pseq[i]   = 0;
      wait_g[i] = 0;
    end
    for (int c = 0; c < 256; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i] = 1'b1;
          pd[i] = {i[1:0], pseq[i][5:0]};
          pseq[i]++;
        end
      end
      dd = '0;
      for (int i = 0; i < N; i++) dd[i*W +: W] = pd[i];
      drive_sample(pv, dd);
      if (busy && !prev_busy) begin
        for (int i = 0; i < N; i++) begin
          if (i == int'(grant_id)) wait_g[i] = 0;
          else if (pv[i]) begin
            wait_g[i]++;
            if (wait_g[i] > max_wait) max_wait = wait_g[i];
          end
        end
      end
      prev_busy = busy;
      for (int i = 0; i < N; i++) begin
        if (pv[i] && req_ready[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pd[i] = {i[1:0], pseq[i][5:0]};
            pseq[i]++;
          end else begin
            pv[i] = 1'b0;
          end
        end
        if (!pv[i]) wait_g[i] = 0;
      end
      finish_cycle($urandom_range(0, 9) < 4);
    end
    for (int c = 0; c < 40 && fq.size() > 0; c++) cycle('0, '0, 1'b1);
    sb_left = 0;
    for (int i = 0; i < N; i++) sb_left += sb[i].size();
    chk("t6_drained", 64'(fq.size()), 64'd0);
    chk("t6_sb_left", 64'(sb_left), 64'd0);
    chk("t6_starve", {63'd0, (max_wait <= N - 1)}, 64'd1);
    chk("t6_traffic", {63'd0, (we_count > 20)}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
